// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types for the memory bus: the master request/response payloads, the
// routing entry kept per outstanding request, the all-ones error response and
// the address-window priority decoder used by mem_router.
//
// Optional feature macro: MEM_ROUTER_DECERR_EN adds the decode-error bit to
// mem_route_entry (see mem_router).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_ADDR_W     = 32;
    localparam int MEM_DATA_W     = 32;
    // Upper bound on router fan-out; sizes the slave index in the route queue.
    localparam int MEM_MAX_SLAVES = 16;
    localparam int MEM_IDX_W      = 4;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [MEM_DATA_W-1:0] wdata;
    } mreq;

    typedef logic [MEM_DATA_W-1:0] mresp;

    // Response returned by the router itself for an unmapped address.
    localparam mresp MEM_ROUTER_ERR_DATA = mresp'('1);

    // One entry per outstanding request: which slave owes the response.
    typedef struct packed {
`ifdef MEM_ROUTER_DECERR_EN
        logic                 err;
`endif
        logic [MEM_IDX_W-1:0] idx;
    } mem_route_entry;

    typedef struct packed {
        logic                 found;
        logic [MEM_IDX_W-1:0] idx;
    } mem_decode_t;

    // Priority decode of the per-window hit vector: lowest index wins.
    function automatic mem_decode_t mem_decode(input logic [MEM_MAX_SLAVES-1:0] hit);
        mem_decode_t r;
        r.found = 1'b0;
        r.idx   = '0;
        // Scan downwards so the last assignment is the lowest matching index.
        for (int i = MEM_MAX_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                r.found = 1'b1;
                r.idx   = MEM_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/queue.sv
// -----------------------------------------------------------------------------
// queue
// Generic valid/ready FIFO with optional fall-through (an empty queue presents
// the incoming entry on its output in the same cycle).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   flush                  synchronous clear of all entries
//   enq_valid/ready/data   write side; ready = not full (a full queue never
//                          accepts, even if it is being read that cycle)
//   deq_valid/ready/data   read side, head entry
// -----------------------------------------------------------------------------
module queue #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter bit FALLTHROUGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic enq_fire;
    logic deq_fire;
    logic store;
    logic pop;

    assign empty     = (count == '0);
    assign enq_ready = (count != CNT_W'(DEPTH));
    assign enq_fire  = enq_valid && enq_ready;

    generate
        if (FALLTHROUGH) begin : g_fallthrough
            assign deq_valid = !empty || enq_fire;
            assign deq_data  = empty ? enq_data : mem[rd_ptr];
        end else begin : g_registered
            assign deq_valid = !empty;
            assign deq_data  = mem[rd_ptr];
        end
    endgenerate

    assign deq_fire = deq_valid && deq_ready;
    // An entry that falls through and is consumed in the same cycle is never stored.
    assign pop      = deq_fire && !empty;
    assign store    = enq_fire && !(empty && deq_fire);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= next_ptr(wr_ptr);
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(store) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are live, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/mem_router.sv
// -----------------------------------------------------------------------------
// mem_router
// Routes one master request/response channel to CNT slaves by address window.
// A request goes to the lowest-indexed slave with (addr & MASK[i]) == BASE[i].
// The destination of every accepted request is queued, and responses are only
// taken from the slave at the queue head, so the master sees responses in
// request order whatever the slave latencies are.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   master_req_*  (valid/ready/addr/we/wdata)   request from the master
//   master_resp_* (valid/ready/data)            in-order response to master
//   slave_req_valid[CNT], slave_req_ready[CNT]  per-slave request handshake;
//   slave_req_addr/we/wdata                     payload shared by all slaves
//   slave_resp_valid[CNT], slave_resp_ready[CNT]
//   slave_resp_data[CNT*MEM_DATA_W]             slave j at [j*MEM_DATA_W +: MEM_DATA_W]
//
// Optional feature macro: MEM_ROUTER_DECERR_EN
//   defined   - an unmapped address is accepted by the router itself and
//               answered in order with MEM_ROUTER_ERR_DATA (all ones).
//   undefined - an unmapped address goes to slave CNT-1 (default slave).
// -----------------------------------------------------------------------------
module mem_router
    import mem_pkg::*;
#(
    parameter int                    CNT         = 2,
    parameter int                    QUEUE_DEPTH = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE [CNT]  = '{32'h0000_0000, 32'h8000_0000},
    parameter logic [ADDR_WIDTH-1:0] MASK [CNT]  = '{32'h8000_0000, 32'h8000_0000}
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      master_req_valid,
    output logic                      master_req_ready,
    input  logic [ADDR_WIDTH-1:0]     master_req_addr,
    input  logic                      master_req_we,
    input  logic [MEM_DATA_W-1:0]     master_req_wdata,

    output logic                      master_resp_valid,
    input  logic                      master_resp_ready,
    output logic [MEM_DATA_W-1:0]     master_resp_data,

    output logic [CNT-1:0]            slave_req_valid,
    input  logic [CNT-1:0]            slave_req_ready,
    output logic [ADDR_WIDTH-1:0]     slave_req_addr,
    output logic                      slave_req_we,
    output logic [MEM_DATA_W-1:0]     slave_req_wdata,

    input  logic [CNT-1:0]            slave_resp_valid,
    output logic [CNT-1:0]            slave_resp_ready,
    input  logic [CNT*MEM_DATA_W-1:0] slave_resp_data
);

    // ---------------------------------------------------------------- decode
    logic [MEM_MAX_SLAVES-1:0] hit;
    mem_decode_t               dec;
    logic [MEM_IDX_W-1:0]      sel;
    logic                      route_err;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < CNT; i++) begin
            hit[i] = ((master_req_addr & MASK[i]) == BASE[i]);
        end
    end

    assign dec = mem_decode(hit);

`ifdef MEM_ROUTER_DECERR_EN
    assign route_err = !dec.found;
    assign sel       = dec.found ? dec.idx : '0;
`else
    assign route_err = 1'b0;
    assign sel       = dec.found ? dec.idx : MEM_IDX_W'(CNT - 1);
`endif

    // ----------------------------------------------------------- route queue
    mem_route_entry enq_entry;
    mem_route_entry head;
    logic           q_enq_valid;
    logic           q_enq_ready;
    logic           head_valid;
    logic           q_deq_ready;

    queue #(
        .WIDTH       ($bits(mem_route_entry)),
        .DEPTH       (QUEUE_DEPTH),
        .FALLTHROUGH (1'b1)
    ) u_route_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .enq_valid (q_enq_valid),
        .enq_ready (q_enq_ready),
        .enq_data  (enq_entry),
        .deq_valid (head_valid),
        .deq_ready (q_deq_ready),
        .deq_data  (head)
    );

    // ---------------------------------------------------------- request path
    logic enq_ok;
    logic sel_ready;

    // The queue reads as empty (ready) during reset, so gate it explicitly.
    assign enq_ok = q_enq_ready && !rst;

    always_comb begin
        sel_ready = 1'b0;
        for (int j = 0; j < CNT; j++) begin
            if (sel == MEM_IDX_W'(j)) sel_ready = slave_req_ready[j];
        end
    end

    always_comb begin
        slave_req_valid = '0;
        for (int j = 0; j < CNT; j++) begin
            slave_req_valid[j] = master_req_valid && enq_ok && !route_err &&
                                 (sel == MEM_IDX_W'(j));
        end
    end

    // A decode error is absorbed by the router, so no slave ready is needed.
    assign master_req_ready = enq_ok && (route_err || sel_ready);
    assign q_enq_valid      = master_req_valid && master_req_ready;

    assign enq_entry.idx = sel;
`ifdef MEM_ROUTER_DECERR_EN
    assign enq_entry.err = route_err;
`endif

    assign slave_req_addr  = master_req_addr;
    assign slave_req_we    = master_req_we;
    assign slave_req_wdata = master_req_wdata;

    // --------------------------------------------------------- response path
    logic                  head_err;
    logic                  head_resp_valid;
    logic [MEM_DATA_W-1:0] head_resp_data;

`ifdef MEM_ROUTER_DECERR_EN
    assign head_err = head.err;
`else
    assign head_err = 1'b0;
`endif

    always_comb begin
        head_resp_valid = 1'b0;
        head_resp_data  = '0;
        for (int j = 0; j < CNT; j++) begin
            if (head.idx == MEM_IDX_W'(j)) begin
                head_resp_valid = slave_resp_valid[j];
                head_resp_data  = slave_resp_data[j*MEM_DATA_W +: MEM_DATA_W];
            end
        end
    end

    assign master_resp_valid = head_valid && (head_err || head_resp_valid);
    assign master_resp_data  = head_err ? MEM_ROUTER_ERR_DATA : head_resp_data;

    // Only the head's slave is ever acknowledged; others are stalled, not dropped.
    always_comb begin
        slave_resp_ready = '0;
        for (int j = 0; j < CNT; j++) begin
            slave_resp_ready[j] = master_resp_ready && head_valid && !head_err &&
                                  !rst && (head.idx == MEM_IDX_W'(j));
        end
    end

    // Pop exactly on the master response handshake.
    assign q_deq_ready = master_resp_ready && (head_err || head_resp_valid);

endmodule

// File: tb/tb_mem_router.sv
// -----------------------------------------------------------------------------
// tb_mem_router
// Directed bench for mem_router (CNT=2, QUEUE_DEPTH=4). Window map:
//   slave 0: 0x0000_0000-0x3FFF_FFFF, slave 1: 0x8000_0000-0xFFFF_FFFF,
//   0x4000_0000-0x7FFF_FFFF unmapped (error response with
//   MEM_ROUTER_DECERR_EN, otherwise routed to slave 1).
// -----------------------------------------------------------------------------
module tb_mem_router;
    import mem_pkg::*;

    localparam int CNT = 2;
    localparam int DW  = MEM_DATA_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            master_req_valid;
    logic            master_req_ready;
    logic [31:0]     master_req_addr;
    logic            master_req_we;
    logic [DW-1:0]   master_req_wdata;
    logic            master_resp_valid;
    logic            master_resp_ready;
    logic [DW-1:0]   master_resp_data;
    logic [CNT-1:0]  slave_req_valid;
    logic [CNT-1:0]  slave_req_ready;
    logic [31:0]     slave_req_addr;
    logic            slave_req_we;
    logic [DW-1:0]   slave_req_wdata;
    logic [CNT-1:0]  slave_resp_valid;
    logic [CNT-1:0]  slave_resp_ready;
    logic [CNT*DW-1:0] slave_resp_data;

    mem_router #(
        .CNT         (CNT),
        .QUEUE_DEPTH (4),
        .ADDR_WIDTH  (32),
        .BASE        ('{32'h0000_0000, 32'h8000_0000}),
        .MASK        ('{32'hC000_0000, 32'h8000_0000})
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .master_req_valid  (master_req_valid),
        .master_req_ready  (master_req_ready),
        .master_req_addr   (master_req_addr),
        .master_req_we     (master_req_we),
        .master_req_wdata  (master_req_wdata),
        .master_resp_valid (master_resp_valid),
        .master_resp_ready (master_resp_ready),
        .master_resp_data  (master_resp_data),
        .slave_req_valid   (slave_req_valid),
        .slave_req_ready   (slave_req_ready),
        .slave_req_addr    (slave_req_addr),
        .slave_req_we      (slave_req_we),
        .slave_req_wdata   (slave_req_wdata),
        .slave_resp_valid  (slave_resp_valid),
        .slave_resp_ready  (slave_resp_ready),
        .slave_resp_data   (slave_resp_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle and step past the edge before touching inputs/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        master_req_valid  = 1'b0;
        master_req_addr   = '0;
        master_req_we     = 1'b0;
        master_req_wdata  = '0;
        master_resp_ready = 1'b0;
        slave_req_ready   = 2'b11;
        slave_resp_valid  = 2'b00;
        slave_resp_data   = '0;
    endtask

    task automatic set_resp(input int j, input logic [DW-1:0] d);
        slave_resp_data[j*DW +: DW] = d;
    endtask

    task automatic send(input logic [31:0] a);
        master_req_valid = 1'b1;
        master_req_addr  = a;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        mvalid;
        logic [1:0]  sready;
        logic [1:0]  exp_sreq;
        logic        exp_mready;
        logic        exp_mresp_valid;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    initial begin
        // Request-path decode with an empty queue and no slave responses.
        vecs[0] = '{32'h0000_0010, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0};
        vecs[1] = '{32'h8000_0010, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0};
        vecs[3] = '{32'h3FFF_FFFF, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0000, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0};
`ifdef MEM_ROUTER_DECERR_EN
        // Unmapped: absorbed by the router, error head falls through at once.
        vecs[7] = '{32'h4000_0000, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1};
        vecs[8] = '{32'h4000_0000, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
`else
        // Unmapped: default slave 1.
        vecs[7] = '{32'h4000_0000, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0};
        vecs[8] = '{32'h4000_0000, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
`endif

        // ---------------------------------------------------------- reset
        idle_inputs();
        rst = 1'b1;
        send(32'h0000_0000);
        master_resp_ready = 1'b1;
        slave_resp_valid  = 2'b11;
        #12;
        check("rst_mreq_ready",   master_req_ready,  1'b0);
        check("rst_sreq_valid",   slave_req_valid,   2'b00);
        check("rst_mresp_valid",  master_resp_valid, 1'b0);
        check("rst_sresp_ready",  slave_resp_ready,  2'b00);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();

        // ---------------------------------------------------------- table
        for (int i = 0; i < NVEC; i++) begin
            master_req_valid = vecs[i].mvalid;
            master_req_addr  = vecs[i].addr;
            slave_req_ready  = vecs[i].sready;
            #1;
            check($sformatf("vec%0d_sreq_valid", i),  slave_req_valid,   vecs[i].exp_sreq);
            check($sformatf("vec%0d_mreq_ready", i),  master_req_ready,  vecs[i].exp_mready);
            check($sformatf("vec%0d_mresp_valid", i), master_resp_valid, vecs[i].exp_mresp_valid);
            // Withdraw before the edge so the queue stays empty.
            master_req_valid = 1'b0;
            tick();
        end
        idle_inputs();

        // ------------------------------------- single request, 3-cycle slave
        send(32'h8000_0010);
        master_req_we    = 1'b1;
        master_req_wdata = 32'hCAFE_0001;
        #1;
        check("a_sreq_valid", slave_req_valid, 2'b10);
        check("a_mreq_ready", master_req_ready, 1'b1);
        check("a_sreq_addr",  slave_req_addr,  32'h8000_0010);
        check("a_sreq_wdata", slave_req_wdata, 32'hCAFE_0001);
        tick();
        idle_inputs();
        #1;
        check("a_wait_mresp_valid", master_resp_valid, 1'b0);
        tick();
        tick();
        slave_resp_valid  = 2'b10;
        set_resp(1, 32'hDEAD_BEEF);
        master_resp_ready = 1'b1;
        #1;
        check("a_mresp_valid", master_resp_valid, 1'b1);
        check("a_mresp_data",  master_resp_data,  32'hDEAD_BEEF);
        check("a_sresp_ready", slave_resp_ready,  2'b10);
        tick();
        // Slave keeps valid but the queue is now empty: nothing is taken.
        check("a_empty_sresp_ready", slave_resp_ready,  2'b00);
        check("a_empty_mresp_valid", master_resp_valid, 1'b0);
        idle_inputs();

        // ------------------------- A slow slave 0, then B fast slave 1
        send(32'h0000_0010);
        #1;
        check("b_reqA_sreq", slave_req_valid, 2'b01);
        tick();
        send(32'h8000_0020);
        #1;
        check("b_reqB_sreq", slave_req_valid, 2'b10);
        tick();
        master_req_valid  = 1'b0;
        slave_resp_valid  = 2'b10;
        set_resp(1, 32'hBBBB_0001);
        master_resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("b_hold%0d_sresp_ready", c), slave_resp_ready,  2'b01);
            check($sformatf("b_hold%0d_mresp_valid", c), master_resp_valid, 1'b0);
            tick();
        end
        slave_resp_valid = 2'b11;
        set_resp(0, 32'hAAAA_0000);
        #1;
        check("b_A_mresp_valid", master_resp_valid, 1'b1);
        check("b_A_mresp_data",  master_resp_data,  32'hAAAA_0000);
        check("b_A_sresp_ready", slave_resp_ready,  2'b01);
        tick();
        slave_resp_valid = 2'b10;
        #1;
        check("b_B_mresp_valid", master_resp_valid, 1'b1);
        check("b_B_mresp_data",  master_resp_data,  32'hBBBB_0001);
        check("b_B_sresp_ready", slave_resp_ready,  2'b10);
        tick();
        idle_inputs();
        #1;
        check("b_empty_mresp_valid", master_resp_valid, 1'b0);

        // ------------------------------------------------ fill to full
        for (int k = 0; k < 4; k++) begin
            send(32'(k * 16));
            #1;
            check($sformatf("c_fill%0d_mreq_ready", k), master_req_ready, 1'b1);
            tick();
        end
        send(32'h0000_0040);
        #1;
        check("c_full_mreq_ready", master_req_ready, 1'b0);
        check("c_full_sreq_valid", slave_req_valid,  2'b00);
        slave_resp_valid  = 2'b01;
        set_resp(0, 32'h0000_00C0);
        master_resp_ready = 1'b1;
        #1;
        check("c_deq_mresp_data",    master_resp_data, 32'h0000_00C0);
        check("c_deq_full_mreq_rdy", master_req_ready, 1'b0);
        tick();
        slave_resp_valid  = 2'b00;
        master_resp_ready = 1'b0;
        #1;
        check("c_fifth_mreq_ready", master_req_ready, 1'b1);
        check("c_fifth_sreq_valid", slave_req_valid,  2'b01);
        tick();
        master_req_valid  = 1'b0;
        master_resp_ready = 1'b1;
        slave_resp_valid  = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            set_resp(0, 32'(32'hC0 + k));
            #1;
            check($sformatf("c_drain%0d_mresp_valid", k), master_resp_valid, 1'b1);
            check($sformatf("c_drain%0d_mresp_data", k),  master_resp_data,  32'(32'hC0 + k));
            tick();
        end
        check("c_drained_mresp_valid", master_resp_valid, 1'b0);
        idle_inputs();

        // ---------------------------------- master back-pressure 10 cycles
        send(32'h9000_0000);
        tick();
        master_req_valid = 1'b0;
        slave_resp_valid = 2'b10;
        set_resp(1, 32'h1234_5678);
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("d_bp%0d_sresp_ready", c), slave_resp_ready, 2'b00);
            check($sformatf("d_bp%0d_mresp_data", c),  master_resp_data, 32'h1234_5678);
            tick();
        end
        master_resp_ready = 1'b1;
        #1;
        check("d_release_sresp_ready", slave_resp_ready, 2'b10);
        tick();
        idle_inputs();

        // ---------------------------------- reset with 3 outstanding
        send(32'h0000_0000);
        tick();
        send(32'h8000_0000);
        tick();
        send(32'h0000_0004);
        tick();
        send(32'h0000_0000);
        master_resp_ready = 1'b1;
        slave_resp_valid  = 2'b11;
        rst = 1'b1;
        #1;
        check("e_rst_mreq_ready",  master_req_ready,  1'b0);
        check("e_rst_sreq_valid",  slave_req_valid,   2'b00);
        check("e_rst_mresp_valid", master_resp_valid, 1'b0);
        check("e_rst_sresp_ready", slave_resp_ready,  2'b00);
        tick();
        rst = 1'b0;
        master_req_valid = 1'b0;
        #1;
        check("e_post_mresp_valid", master_resp_valid, 1'b0);
        check("e_post_sresp_ready", slave_resp_ready,  2'b00);
        slave_resp_valid = 2'b00;
        send(32'h8000_0004);
        #1;
        check("e_new_sreq_valid", slave_req_valid, 2'b10);
        tick();
        master_req_valid = 1'b0;
        slave_resp_valid = 2'b10;
        set_resp(1, 32'h0000_00E5);
        #1;
        check("e_new_mresp_data", master_resp_data, 32'h0000_00E5);
        tick();
        idle_inputs();

        // ---------------------------------- unmapped address
`ifdef MEM_ROUTER_DECERR_EN
        send(32'h0000_0010);
        tick();
        send(32'h4000_0000);
        #1;
        check("f_err_sreq_valid", slave_req_valid,  2'b00);
        check("f_err_mreq_ready", master_req_ready, 1'b1);
        tick();
        master_req_valid  = 1'b0;
        master_resp_ready = 1'b1;
        #1;
        check("f_wait_mresp_valid", master_resp_valid, 1'b0);
        slave_resp_valid = 2'b01;
        set_resp(0, 32'h0000_0055);
        #1;
        check("f_first_mresp_data", master_resp_data, 32'h0000_0055);
        tick();
        slave_resp_valid = 2'b11;
        #1;
        check("f_err_mresp_valid", master_resp_valid, 1'b1);
        check("f_err_mresp_data",  master_resp_data,  32'hFFFF_FFFF);
        check("f_err_sresp_ready", slave_resp_ready,  2'b00);
        tick();
        slave_resp_valid = 2'b00;
        #1;
        check("f_done_mresp_valid", master_resp_valid, 1'b0);
`else
        send(32'h4000_0000);
        #1;
        check("f_default_sreq_valid", slave_req_valid, 2'b10);
        tick();
        master_req_valid  = 1'b0;
        master_resp_ready = 1'b1;
        slave_resp_valid  = 2'b10;
        set_resp(1, 32'h0000_0066);
        #1;
        check("f_default_mresp_data", master_resp_data, 32'h0000_0066);
        tick();
        slave_resp_valid = 2'b00;
        #1;
        check("f_done_mresp_valid", master_resp_valid, 1'b0);
`endif
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
